// File: rtl/upsp_pkg.sv
// Shared definitions for the up-sampling frame sequencer: FSM encoding,
// CRF register addresses and frame status codes.
package upsp_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_CLR_STR,
      S_SET_END,
      S_WAIT_SW
   } seq_state_t;

   localparam int UPSTR_ADDR  = 0;
   localparam int UPENDR_ADDR = 1;

   localparam logic [1:0] ST_DONE = 2'd1;
   localparam logic [1:0] ST_ERR  = 2'd2;

   // Frame-end status: always "done", plus the error bit when one was seen.
   function automatic logic [1:0] end_status(input logic err);
      return ST_DONE | (err ? ST_ERR : 2'd0);
   endfunction

endpackage

// File: rtl/crf_wr_port.sv
// Single-entry CRF write port: latches a request and holds request, address
// and data stable while the CRF is busy; reports the accepting cycle.
module crf_wr_port
   import upsp_pkg::*;
#(
   parameter int CRF_DATA_WIDTH = 32,
   parameter int CRF_ADDR_WIDTH = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      i_load,
   input  logic [CRF_ADDR_WIDTH-1:0] i_addr,
   input  logic [CRF_DATA_WIDTH-1:0] i_data,
   input  logic                      i_wbusy,
   output logic                      o_wrt,
   output logic [CRF_ADDR_WIDTH-1:0] o_waddr,
   output logic [CRF_DATA_WIDTH-1:0] o_wdata,
   output logic                      o_accept
);

   logic                      r_wrt;
   logic [CRF_ADDR_WIDTH-1:0] r_addr;
   logic [CRF_DATA_WIDTH-1:0] r_data;

   // A new request is only taken while no request is outstanding.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wrt  <= 1'b0;
         r_addr <= '0;
         r_data <= '0;
      end else if (r_wrt) begin
         if (!i_wbusy) r_wrt <= 1'b0;
      end else if (i_load) begin
         r_wrt  <= 1'b1;
         r_addr <= i_addr;
         r_data <= i_data;
      end
   end

   assign o_wrt    = r_wrt;
   assign o_waddr  = r_addr;
   assign o_wdata  = r_data;
   assign o_accept = r_wrt & ~i_wbusy;

endmodule

// File: rtl/upsp_frame_seq.sv
// Up-sampling frame sequencer: starts a frame on a software request, counts
// source/destination lines, watches for stalls and retires the frame via CRF.
module upsp_frame_seq
   import upsp_pkg::*;
#(
   parameter int CRF_DATA_WIDTH = 32,
   parameter int CRF_ADDR_WIDTH = 32,
   parameter int SRC_IMG_HEIGHT = 1080,
   parameter int DST_IMG_HEIGHT = 2160,
   parameter int TIMEOUT_CYCLES = 2**20
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                crf_UPSTR,
   input  logic                                crf_UPENDR,
   input  logic                                crf_wbusy,
   output logic                                seq_crf_wrt,
   output logic [CRF_ADDR_WIDTH-1:0]           seq_crf_waddr,
   output logic [CRF_DATA_WIDTH-1:0]           seq_crf_wdata,
   input  logic                                s_axis_hs,
   input  logic                                s_axis_tlast,
   input  logic                                m_axis_hs,
   input  logic                                m_axis_tlast,
   output logic                                frame_start,
   output logic                                frame_active,
   output logic [$clog2(SRC_IMG_HEIGHT+1)-1:0] src_line_cnt,
   output logic [$clog2(DST_IMG_HEIGHT+1)-1:0] dst_line_cnt,
   output logic                                seq_err
);

   localparam int SW = $clog2(SRC_IMG_HEIGHT+1);
   localparam int DW = $clog2(DST_IMG_HEIGHT+1);
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [SW-1:0] SRC_MAX = SW'(SRC_IMG_HEIGHT);
   localparam logic [DW-1:0] DST_MAX = DW'(DST_IMG_HEIGHT);
   localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYCLES-1);

   seq_state_t  r_state, w_state_nxt;
   logic [SW-1:0] r_src, w_src_nxt;
   logic [DW-1:0] r_dst, w_dst_nxt, w_dst_inc;
   logic [TW-1:0] r_timer, w_timer_nxt;
   logic          r_err, w_err_nxt;
   logic [1:0]    r_status, w_status_nxt;
   logic          r_start, w_start_nxt;
   logic          r_active;
   logic          w_load, w_wrt, w_accept;
   logic [CRF_ADDR_WIDTH-1:0] w_addr;
   logic [CRF_DATA_WIDTH-1:0] w_data;

   assign w_dst_inc = r_dst + DW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_src    <= '0;
         r_dst    <= '0;
         r_timer  <= '0;
         r_err    <= 1'b0;
         r_status <= '0;
         r_start  <= 1'b0;
         r_active <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_src    <= w_src_nxt;
         r_dst    <= w_dst_nxt;
         r_timer  <= w_timer_nxt;
         r_err    <= w_err_nxt;
         r_status <= w_status_nxt;
         r_start  <= w_start_nxt;
         r_active <= (w_state_nxt == S_RUN);
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_src_nxt    = r_src;
      w_dst_nxt    = r_dst;
      w_timer_nxt  = r_timer;
      w_err_nxt    = r_err;
      w_status_nxt = r_status;
      w_start_nxt  = 1'b0;
      w_load       = 1'b0;
      w_addr       = CRF_ADDR_WIDTH'(UPSTR_ADDR);
      w_data       = '0;
      case (r_state)
         S_IDLE: begin
            if (crf_UPSTR && !crf_UPENDR) begin
               w_state_nxt = S_RUN;
               w_src_nxt   = '0;
               w_dst_nxt   = '0;
               w_timer_nxt = '0;
               w_err_nxt   = 1'b0;
               w_start_nxt = 1'b1;
            end
         end
         S_RUN: begin
            // Source overrun flags an error and the count saturates.
            if (s_axis_hs && s_axis_tlast) begin
               if (r_src == SRC_MAX) w_err_nxt = 1'b1;
               else                  w_src_nxt = r_src + SW'(1);
            end
            if (m_axis_hs && m_axis_tlast) w_dst_nxt = w_dst_inc;
            if (s_axis_hs || m_axis_hs) w_timer_nxt = '0;
            else                        w_timer_nxt = r_timer + TW'(1);
            // Completion outranks timeout, which outranks a software abort.
            if (m_axis_hs && m_axis_tlast && (w_dst_inc == DST_MAX)) begin
               w_state_nxt  = S_CLR_STR;
               w_status_nxt = end_status(w_err_nxt);
            end else if (!s_axis_hs && !m_axis_hs && (r_timer == TO_MAX)) begin
               w_err_nxt    = 1'b1;
               w_state_nxt  = S_CLR_STR;
               w_status_nxt = ST_DONE | ST_ERR;
            end else if (!crf_UPSTR) begin
               w_state_nxt  = S_SET_END;
               w_status_nxt = end_status(w_err_nxt);
            end
         end
         S_CLR_STR: begin
            w_load = !w_wrt;
            if (w_accept) w_state_nxt = S_SET_END;
         end
         S_SET_END: begin
            w_load = !w_wrt;
            w_addr = CRF_ADDR_WIDTH'(UPENDR_ADDR);
            w_data = {{(CRF_DATA_WIDTH-2){1'b0}}, r_status};
            if (w_accept) w_state_nxt = S_WAIT_SW;
         end
         S_WAIT_SW: begin
            if (!crf_UPENDR) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   crf_wr_port #(
      .CRF_DATA_WIDTH (CRF_DATA_WIDTH),
      .CRF_ADDR_WIDTH (CRF_ADDR_WIDTH)
   ) u_crf_wr_port (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_load   (w_load),
      .i_addr   (w_addr),
      .i_data   (w_data),
      .i_wbusy  (crf_wbusy),
      .o_wrt    (w_wrt),
      .o_waddr  (seq_crf_waddr),
      .o_wdata  (seq_crf_wdata),
      .o_accept (w_accept)
   );

   assign seq_crf_wrt  = w_wrt;
   assign frame_start  = r_start;
   assign frame_active = r_active;
   assign src_line_cnt = r_src;
   assign dst_line_cnt = r_dst;
   assign seq_err      = r_err;

endmodule
